// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register bank with a hardwired-zero r0 and
// a per-register pending-write counter. Decode uses the counter through the
// rd_busy outputs to stall issue, and through iss_ready to avoid overflowing it.
// Optional macro REGFILE_BYPASS_EN adds a write-through path from the writeback
// port to both read ports. The default build, with the macro undefined, has no
// bypass.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = $clog2(NREG),
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];

  logic              retire;
  logic              iss_acc;
  logic              underflow_now;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;

  // A writeback to r0 carries no data and retires nothing.
  assign retire  = wr_en && (wr_addr != '0);

  // A saturated counter can still take an issue if a retire frees a slot in the same cycle.
  assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) ||
                     (retire && (wr_addr == iss_addr));
  assign iss_acc   = iss_en && iss_ready && (iss_addr != '0);

  // An issue and a retire on the same register cancel, so only a lone retire can underflow.
  assign underflow_now = retire && !(iss_acc && (iss_addr == wr_addr)) &&
                         (cnt[wr_addr] == '0);

  // One-hot increment/decrement requests per register.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_acc) inc_vec[iss_addr] = 1'b1;
    if (retire)  dec_vec[wr_addr]  = 1'b1;
  end

  function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (reset && (a != '0)) begin
      d = regs[a];
`ifdef REGFILE_BYPASS_EN
      if (retire && (wr_addr == a)) d = wr_data;
`endif
    end
    return d;
  endfunction

  function automatic logic read_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    if (reset && (a != '0)) begin
      b = (cnt[a] != '0);
`ifdef REGFILE_BYPASS_EN
      // The last pending write lands this cycle, so the reader sees it through the bypass.
      if (retire && (wr_addr == a) && (cnt[a] == CNT_ONE) &&
          !(iss_acc && (iss_addr == a)))
        b = 1'b0;
`endif
    end
    return b;
  endfunction

  // Combinational read ports; r0 and the reset state always read as idle zero.
  always_comb begin
    rd_data1 = read_data(rd_addr1);
    rd_data2 = read_data(rd_addr2);
    rd_busy1 = read_busy(rd_addr1);
    rd_busy2 = read_busy(rd_addr2);
  end

  // Register storage: a retiring writeback updates its destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (retire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Pending-write counters and the sticky underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CNT_ONE;
      end
      if (underflow_now) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a queue of expected observations.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int S_D1 = 0, S_D2 = 1, S_B1 = 2, S_B2 = 3, S_RDY = 4, S_ERR = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, iss_addr, wr_addr;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data;
  logic              rd_busy1, rd_busy2, iss_en, iss_ready, wr_en, err_underflow;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;

  regfile_scoreboard #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_D1:    return rd_data1;
      S_D2:    return rd_data2;
      S_B1:    return {31'b0, rd_busy1};
      S_B2:    return {31'b0, rd_busy2};
      S_RDY:   return {31'b0, iss_ready};
      S_ERR:   return {31'b0, err_underflow};
      default: return 'x;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h, expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic ie, input logic [ADDR_W-1:0] ia,
                       input logic we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd);
    iss_en   = ie;
    iss_addr = ia;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rd_addr1 = '0; rd_addr2 = '0;
    drive(1'b0, '0, 1'b0, '0, '0);
    #1 reset = 1'b0;
    #1;

    // Reset values on several addresses
    rd_addr1 = 5'd0; rd_addr2 = 5'd5; iss_addr = 5'd0;
    push_exp("rst_d1_r0", S_D1, 32'h0);
    push_exp("rst_d2_r5", S_D2, 32'h0);
    push_exp("rst_b1_r0", S_B1, 32'h0);
    push_exp("rst_b2_r5", S_B2, 32'h0);
    push_exp("rst_rdy",   S_RDY, 32'h1);
    push_exp("rst_err",   S_ERR, 32'h0);
    check_all();
    rd_addr1 = 5'd31; iss_addr = 5'd31;
    push_exp("rst_d1_r31",  S_D1, 32'h0);
    push_exp("rst_b1_r31",  S_B1, 32'h0);
    push_exp("rst_rdy_r31", S_RDY, 32'h1);
    check_all();
    #14 reset = 1'b1;
    tick();

    // Issue r3, then write it back
    rd_addr1 = 5'd3;
    drive(1'b1, 5'd3, 1'b0, '0, '0);
    push_exp("r3_busy_pre_issue", S_B1, 32'h0);
    check_all();
    tick();
    drive(1'b0, '0, 1'b1, 5'd3, 32'hDEADBEEF);
    push_exp("r3_busy_during_wb", S_B1, BYP ? 32'h0 : 32'h1);
    push_exp("r3_data_during_wb", S_D1, BYP ? 32'hDEADBEEF : 32'h0);
    check_all();
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    push_exp("r3_data_after_wb", S_D1, 32'hDEADBEEF);
    push_exp("r3_busy_after_wb", S_B1, 32'h0);
    check_all();

    // Saturate r7's counter
    rd_addr2 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd7, 1'b0, '0, '0);
      push_exp($sformatf("r7_ready_issue%0d", k), S_RDY, 32'h1);
      check_all();
      tick();
    end
    drive(1'b1, 5'd7, 1'b0, '0, '0);
    push_exp("r7_ready_saturated", S_RDY, 32'h0);
    push_exp("r7_busy_saturated",  S_B2,  32'h1);
    check_all();
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 32'h77);
    push_exp("r7_ready_iss_and_retire", S_RDY, 32'h1);
    check_all();
    tick();
    drive(1'b1, 5'd7, 1'b0, '0, '0);
    push_exp("r7_ready_still_saturated", S_RDY, 32'h0);
    check_all();
    // Drain r7: exactly three retires must bring the counter to zero
    drive(1'b0, '0, 1'b1, 5'd7, 32'h70);
    push_exp("r7_busy_cnt3", S_B2, 32'h1);
    check_all();
    tick();
    drive(1'b0, '0, 1'b1, 5'd7, 32'h71);
    push_exp("r7_busy_cnt2", S_B2, 32'h1);
    check_all();
    tick();
    drive(1'b0, '0, 1'b1, 5'd7, 32'h72);
    push_exp("r7_busy_last_retire", S_B2, BYP ? 32'h0 : 32'h1);
    push_exp("r7_data_last_retire", S_D2, BYP ? 32'h72 : 32'h71);
    check_all();
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    push_exp("r7_busy_drained", S_B2, 32'h0);
    push_exp("r7_data_drained", S_D2, 32'h72);
    push_exp("r7_err_none",     S_ERR, 32'h0);
    check_all();

    // r0 is hardwired to zero and never tracked
    rd_addr1 = 5'd0;
    drive(1'b1, 5'd0, 1'b1, 5'd0, 32'h1234);
    push_exp("r0_ready",   S_RDY, 32'h1);
    push_exp("r0_data_wb", S_D1,  32'h0);
    push_exp("r0_busy_wb", S_B1,  32'h0);
    check_all();
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    push_exp("r0_data_after", S_D1,  32'h0);
    push_exp("r0_busy_after", S_B1,  32'h0);
    push_exp("r0_err_after",  S_ERR, 32'h0);
    check_all();

    // Retire r9 with no pending issue
    drive(1'b0, '0, 1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    rd_addr1 = 5'd9;
    push_exp("r9_data_written", S_D1,  32'h99);
    push_exp("r9_busy",         S_B1,  32'h0);
    push_exp("r9_err_set",      S_ERR, 32'h1);
    check_all();
    repeat (3) tick();
    push_exp("r9_err_sticky", S_ERR, 32'h1);
    check_all();

    // Same-cycle read of a register being written
    rd_addr1 = 5'd4; rd_addr2 = 5'd3;
    drive(1'b0, '0, 1'b1, 5'd4, 32'hA5A5A5A5);
    push_exp("r4_data_same_cycle", S_D1, BYP ? 32'hA5A5A5A5 : 32'h0);
    push_exp("r3_data_port2",      S_D2, 32'hDEADBEEF);
    check_all();
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    push_exp("r4_data_next_cycle", S_D1, 32'hA5A5A5A5);
    check_all();

    // Asynchronous reset in the middle of activity
    drive(1'b1, 5'd5, 1'b0, '0, '0);
    tick();
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd4, 32'hCAFEF00D);
    rd_addr2 = 5'd5;
    push_exp("r5_busy_pre_reset", S_B2, 32'h1);
    check_all();
    #1 reset = 1'b0;
    push_exp("midrst_d1",  S_D1,  32'h0);
    push_exp("midrst_b2",  S_B2,  32'h0);
    push_exp("midrst_rdy", S_RDY, 32'h1);
    push_exp("midrst_err", S_ERR, 32'h0);
    check_all();
    tick();
    drive(1'b0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    rd_addr1 = 5'd3;
    push_exp("postrst_r3_data", S_D1,  32'h0);
    push_exp("postrst_r5_busy", S_B2,  32'h0);
    push_exp("postrst_err",     S_ERR, 32'h0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
